linear_layer_start_fifo: RTL

LINEAR_LAYER_START_FIFO -- requirements
Module: linear_layer_start_fifo

---
 rtl/linear_layer_start_fifo_srl.sv | 32 +++
 rtl/linear_layer_start_fifo.sv | 108 ++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-register storage for linear_layer_start_fifo: a push enters at entry 0 and
// every older token moves up one slot. The read port is a plain combinational mux.
module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage has no reset and no read-side logic, so it stays SRL-compatible
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Show-ahead read of the entry selected by the parent's pointer
  always_comb begin
    dout = mem_q[addr];
  end

endmodule

// File: rtl/linear_layer_start_fifo.sv
// Shift-register FIFO with show-ahead output. The parent owns the occupancy pointer
// and both flags; the SRL sub-module holds only the data.
module linear_layer_start_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  // All-ones encodes "empty"; value k encodes k+1 tokens held
  localparam logic [PTR_W-1:0] PTR_EMPTY       = {PTR_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_LAST_FREE   = PTR_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE_HELD    = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_STEP        = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0]      ptr_q,     ptr_d;
  logic                  full_n_q,  full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] raddr_s;

  // Accepted handshakes only look at registered flags, never at outputs of this cycle's logic
  always_comb begin
    push_s = if_write & if_write_ce & full_n_q;
    pop_s  = if_read  & if_read_ce  & empty_n_q;
  end

  // Pointer and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= PTR_EMPTY;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  // Next occupancy: a simultaneous push and pop only shifts storage
  always_comb begin
    ptr_d     = ptr_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    case ({push_s, pop_s})
      2'b10: begin
        ptr_d     = ptr_q + PTR_STEP;
        empty_n_d = 1'b1;
        if (ptr_q == PTR_LAST_FREE) begin
          full_n_d = 1'b0;
        end else begin
          full_n_d = full_n_q;
        end
      end
      2'b01: begin
        ptr_d    = ptr_q - PTR_STEP;
        full_n_d = 1'b1;
        if (ptr_q == PTR_ONE_HELD) begin
          empty_n_d = 1'b0;
        end else begin
          empty_n_d = empty_n_q;
        end
      end
      default: begin
        ptr_d     = ptr_q;
        full_n_d  = full_n_q;
        empty_n_d = empty_n_q;
      end
    endcase
  end

  // Outputs: flags straight from registers, read address clamps to 0 when empty
  always_comb begin
    if_full_n  = full_n_q;
    if_empty_n = empty_n_q;
    if (ptr_q[ADDR_WIDTH]) begin
      raddr_s = {ADDR_WIDTH{1'b0}};
    end else begin
      raddr_s = ptr_q[ADDR_WIDTH-1:0];
    end
  end

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push_s),
    .addr (raddr_s),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule
